// File: rtl/reg_word_serializer.sv
// Parallel-to-serial readout: loads one WIDTH-bit word on a valid/ready handshake and emits it LSB-first.
// Optional even-parity trailer bit when SERIALIZER_PARITY_EN is defined.
module reg_word_serializer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy,
  output logic [15:0]      frame_count
);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_PAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SEND} state_t;
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               last_data;
`ifdef SERIALIZER_PARITY_EN
  logic               par_q, par_d;
`endif

  assign last_data = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
`ifdef SERIALIZER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef SERIALIZER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
`ifdef SERIALIZER_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          cnt_d   = '0;
          state_d = S_SEND;
`ifdef SERIALIZER_PARITY_EN
          par_d   = ^in_data;
`endif
        end
      end
      S_SEND: begin
        if (ser_ready) begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          if (last_data) begin
`ifdef SERIALIZER_PARITY_EN
            state_d = S_PAR;
`else
            state_d     = S_IDLE;
            frame_cnt_d = frame_cnt_q + 16'd1;
`endif
          end
        end
      end
`ifdef SERIALIZER_PARITY_EN
      S_PAR: begin
        if (ser_ready) begin
          state_d     = S_IDLE;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // All outputs decode from registered state only; no input-to-output paths.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = ~in_ready;
    ser_valid = ~in_ready;
    ser_out   = 1'b0;
    ser_last  = 1'b0;
    case (state_q)
      S_SEND: begin
        ser_out = shreg_q[0];
`ifndef SERIALIZER_PARITY_EN
        ser_last = last_data;
`endif
      end
`ifdef SERIALIZER_PARITY_EN
      S_PAR: begin
        ser_out  = par_q;
        ser_last = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign frame_count = frame_cnt_q;

endmodule
